// File: rtl/debug_pkg.sv
// Shared constants and types for the register-file debug dumper.
// Frame geometry, FSM states and an index-width helper.
package debug_pkg;

   localparam int BYTES_PER_REG = 5;
   localparam int REG_COUNT_DEF = 32;
   localparam int FRAME_BYTES   = REG_COUNT_DEF * BYTES_PER_REG;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   // Width of a register index, never below one bit.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debug_byte_select.sv
// Picks one byte of the debug frame from a register snapshot.
// Byte 0 is the register index, bytes 1..4 are its data MSB first.
module debug_byte_select
   import debug_pkg::*;
#(
   parameter  int REG_COUNT = 32,
   parameter  int REG_WIDTH = 32,
   localparam int RIW       = idx_bits(REG_COUNT)
) (
   input  logic [REG_COUNT*REG_WIDTH-1:0] i_snapshot,
   input  logic [RIW-1:0]                 i_reg_idx,
   input  logic [2:0]                     i_byte_idx,
   output logic [7:0]                     o_data
);

   logic [REG_WIDTH-1:0] w_regs [REG_COUNT];
   logic [REG_WIDTH-1:0] w_reg;

   for (genvar k = 0; k < REG_COUNT; k++) begin : g_split
      assign w_regs[k] = i_snapshot[k*REG_WIDTH +: REG_WIDTH];
   end

   assign w_reg = w_regs[i_reg_idx];

   // Index byte first, then the selected register big-endian.
   always_comb begin
      o_data = '0;
      case (i_byte_idx)
         3'd0:    o_data = 8'(i_reg_idx);
         3'd1:    o_data = w_reg[31:24];
         3'd2:    o_data = w_reg[23:16];
         3'd3:    o_data = w_reg[15:8];
         3'd4:    o_data = w_reg[7:0];
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/debug_register_dumper.sv
// Snapshots the register file on request and streams it out as
// index + 4 data bytes per register over a valid/ready byte port.
module debug_register_dumper
   import debug_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int REG_WIDTH = 32
) (
   input  logic                           clock,
   input  logic                           resetN,
   input  logic                           start,
   input  logic [REG_COUNT*REG_WIDTH-1:0] debug_registers,
   output logic                           busy,
   output logic                           outValid,
   input  logic                           outReady,
   output logic [7:0]                     outData,
   output logic                           done
);

   localparam int             RIW      = idx_bits(REG_COUNT);
   localparam logic [RIW-1:0] LAST_REG = RIW'(REG_COUNT - 1);

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [REG_COUNT*REG_WIDTH-1:0] r_snap;
   logic [RIW-1:0]                 r_reg_idx;
   logic [2:0]                     r_byte_idx;
   logic                           w_accept;
   logic                           w_hs;
   logic                           w_last;

   assign w_accept = (r_state == IDLE) && start;
   assign w_hs     = (r_state == SEND) && outReady;
   assign w_last   = w_hs && (r_reg_idx == LAST_REG)
                  && (r_byte_idx == 3'd4);

   // State register.
   always_ff @(posedge clock) begin
      if (!resetN) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state decode: DONE lasts exactly one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SEND;
         SEND:    if (w_last)   w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Snapshot capture on accept; byte/register walk on each handshake.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         r_snap     <= '0;
         r_reg_idx  <= '0;
         r_byte_idx <= '0;
      end else if (w_accept) begin
         r_snap     <= debug_registers;
         r_reg_idx  <= '0;
         r_byte_idx <= '0;
      end else if (w_hs) begin
         if (r_byte_idx == 3'd4) begin
            r_byte_idx <= '0;
            if (r_reg_idx == LAST_REG) r_reg_idx <= '0;
            else                       r_reg_idx <= r_reg_idx + 1'b1;
         end else begin
            r_byte_idx <= r_byte_idx + 3'd1;
         end
      end
   end

   debug_byte_select #(
      .REG_COUNT (REG_COUNT),
      .REG_WIDTH (REG_WIDTH)
   ) u_sel (
      .i_snapshot (r_snap),
      .i_reg_idx  (r_reg_idx),
      .i_byte_idx (r_byte_idx),
      .o_data     (outData)
   );

   assign busy     = (r_state == SEND);
   assign outValid = (r_state == SEND);
   assign done     = (r_state == DONE);

endmodule

// File: tb/tb_debug_register_dumper.sv
// Randomized self-checking bench for debug_register_dumper.
// Expected frames come from a queue model of the register image.
module tb_debug_register_dumper;
   import debug_pkg::*;

   localparam int MAXC = 3000;

   logic          clock;
   logic          resetN;
   logic          start;
   logic [1023:0] bus;
   logic          busy;
   logic          outValid;
   logic          outReady;
   logic [7:0]    outData;
   logic          done;

   logic [31:0] regs [32];
   logic [7:0]  got [$];
   logic [7:0]  exp [$];
   int          n_tests;
   int          n_fail;

   debug_register_dumper dut (
      .clock           (clock),
      .resetN          (resetN),
      .start           (start),
      .debug_registers (bus),
      .busy            (busy),
      .outValid        (outValid),
      .outReady        (outReady),
      .outData         (outData),
      .done            (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic load_bus();
      for (int k = 0; k < 32; k++) bus[k*32 +: 32] = regs[k];
   endtask

   task automatic rand_regs();
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      regs[0] = 32'h0;
      load_bus();
   endtask

   // Reference frame: index byte, then the word big-endian.
   task automatic make_exp();
      exp.delete();
      for (int k = 0; k < 32; k++) begin
         exp.push_back(8'(k));
         for (int b = 3; b >= 0; b--)
            exp.push_back(8'(regs[k] >> (8 * b)));
      end
   endtask

   function automatic int diff_cnt();
      int d;
      d = (got.size() != exp.size()) ? 1 : 0;
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         if (got[i] !== exp[i]) d++;
      return d;
   endfunction

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // Drains the port with random ready, recording bytes and events.
   task automatic collect(
      input  int pct,
      input  int start_at,
      input  bit start_on_done,
      input  int rst_at,
      output int done_at,
      output int done_cnt,
      output int stall_err,
      output bit v_at_done,
      output bit b_at_done
   );
      logic [7:0] prev;
      bit         stalled;
      int         extra;
      got.delete();
      done_at   = -1;
      done_cnt  = 0;
      stall_err = 0;
      v_at_done = 1'b1;
      b_at_done = 1'b1;
      stalled   = 1'b0;
      prev      = '0;
      extra     = -1;
      for (int i = 0; i < MAXC; i++) begin
         outReady = ($urandom_range(99) < pct);
         start    = 1'b0;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at   = i;
               v_at_done = outValid;
               b_at_done = busy;
               extra     = 3;
            end
            if (start_on_done) start = 1'b1;
         end
         if (start_at >= 0 && outValid && got.size() == start_at)
            start = 1'b1;
         if (stalled && (outValid !== 1'b1 || outData !== prev))
            stall_err++;
         if (rst_at >= 0 && got.size() == rst_at) begin
            resetN = 1'b0;
            cyc();
            resetN   = 1'b1;
            outReady = 1'b0;
            start    = 1'b0;
            return;
         end
         if (outValid && outReady) got.push_back(outData);
         stalled = outValid && !outReady;
         prev    = outData;
         cyc();
         if (extra > 0) begin
            extra--;
            if (extra == 0) break;
         end
      end
      start    = 1'b0;
      outReady = 1'b0;
   endtask

   task automatic test_reset();
      resetN   = 1'b0;
      start    = 1'b0;
      outReady = 1'b0;
      rand_regs();
      repeat (3) cyc();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_tests++;
      if (outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", outValid);
      end
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      n_tests++;
      if (outData !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 00", outData);
      end
      resetN = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      int da, dc, se, d;
      bit va, ba;
      logic [7:0] head [10];
      head = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      rand_regs();
      regs[1] = 32'h12345678;
      load_bus();
      make_exp();
      do_start();
      n_tests++;
      if (outValid !== 1'b1 || busy !== 1'b1 || outData !== 8'h00) begin
         n_fail++;
         $display("FAIL start_outputs: got v=%b b=%b d=%h want 1 1 00",
                  outValid, busy, outData);
      end
      collect(100, -1, 1'b0, -1, da, dc, se, va, ba);
      d = diff_cnt();
      n_tests++;
      if (d !== 0) begin
         n_fail++;
         $display("FAIL basic_frame: got %0d bytes %0d diffs want %0d bytes 0",
                  got.size(), d, FRAME_BYTES);
      end
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if ((got.size() > i ? got[i] : 8'hxx) !== head[i]) begin
            n_fail++;
            $display("FAIL basic_head[%0d]: got %h want %h", i,
                     (got.size() > i ? got[i] : 8'hxx), head[i]);
         end
      end
      n_tests++;
      if (da !== 160) begin
         n_fail++;
         $display("FAIL basic_done_cycle: got %0d want 160", da);
      end
      n_tests++;
      if (va !== 1'b0 || ba !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_outputs: got v=%b b=%b want 0 0", va, ba);
      end
      n_tests++;
      if (dc !== 1) begin
         n_fail++;
         $display("FAIL basic_done_count: got %0d want 1", dc);
      end
   endtask

   task automatic test_backpressure();
      int da, dc, se, d;
      bit va, ba;
      logic [7:0] tail [5];
      tail = '{8'h1F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      rand_regs();
      regs[31] = 32'hDEADBEEF;
      load_bus();
      make_exp();
      do_start();
      collect(50, -1, 1'b0, -1, da, dc, se, va, ba);
      d = diff_cnt();
      n_tests++;
      if (d !== 0) begin
         n_fail++;
         $display("FAIL bp_frame: got %0d bytes %0d diffs want 160 bytes 0",
                  got.size(), d);
      end
      n_tests++;
      if (se !== 0) begin
         n_fail++;
         $display("FAIL bp_stall_stable: got %0d changes want 0", se);
      end
      for (int j = 0; j < 5; j++) begin
         n_tests++;
         if ((got.size() > 155 + j ? got[155+j] : 8'hxx) !== tail[j]) begin
            n_fail++;
            $display("FAIL bp_tail[%0d]: got %h want %h", j,
                     (got.size() > 155 + j ? got[155+j] : 8'hxx), tail[j]);
         end
      end
      n_tests++;
      if (dc !== 1) begin
         n_fail++;
         $display("FAIL bp_done_count: got %0d want 1", dc);
      end
   endtask

   task automatic test_snapshot();
      int da, dc, se, d;
      bit va, ba;
      logic [7:0] want [4];
      want = '{8'hAA, 8'hAA, 8'h00, 8'h00};
      rand_regs();
      regs[5] = 32'hAAAA0000;
      load_bus();
      make_exp();
      do_start();
      outReady = 1'b0;
      cyc();
      bus[5*32 +: 32] = 32'h5555FFFF;
      collect(100, -1, 1'b0, -1, da, dc, se, va, ba);
      d = diff_cnt();
      n_tests++;
      if (d !== 0) begin
         n_fail++;
         $display("FAIL snap_frame: got %0d bytes %0d diffs want 160 bytes 0",
                  got.size(), d);
      end
      for (int j = 0; j < 4; j++) begin
         n_tests++;
         if ((got.size() > 26 + j ? got[26+j] : 8'hxx) !== want[j]) begin
            n_fail++;
            $display("FAIL snap_reg5[%0d]: got %h want %h", j,
                     (got.size() > 26 + j ? got[26+j] : 8'hxx), want[j]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int da, dc, se, d;
      bit va, ba;
      rand_regs();
      make_exp();
      do_start();
      collect(70, 37, 1'b1, -1, da, dc, se, va, ba);
      d = diff_cnt();
      n_tests++;
      if (d !== 0) begin
         n_fail++;
         $display("FAIL ign_frame: got %0d bytes %0d diffs want 160 bytes 0",
                  got.size(), d);
      end
      n_tests++;
      if (dc !== 1) begin
         n_fail++;
         $display("FAIL ign_done_count: got %0d want 1", dc);
      end
      n_tests++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_idle_after: got v=%b b=%b want 0 0",
                  outValid, busy);
      end
   endtask

   task automatic test_abort();
      int da, dc, se, d, bad;
      bit va, ba;
      rand_regs();
      make_exp();
      do_start();
      collect(100, -1, 1'b0, 80, da, dc, se, va, ba);
      n_tests++;
      if (got.size() !== 80 || outValid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got n=%0d v=%b b=%b want 80 0 0",
                  got.size(), outValid, busy);
      end
      bad = dc;
      for (int i = 0; i < 6; i++) begin
         if (done !== 1'b0 || outValid !== 1'b0) bad++;
         cyc();
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d bad cycles want 0", bad);
      end
      rand_regs();
      make_exp();
      do_start();
      n_tests++;
      if (outValid !== 1'b1 || outData !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_restart: got v=%b d=%h want 1 00",
                  outValid, outData);
      end
      collect(100, -1, 1'b0, -1, da, dc, se, va, ba);
      d = diff_cnt();
      n_tests++;
      if (d !== 0 || dc !== 1) begin
         n_fail++;
         $display("FAIL abort_frame: got %0d bytes %0d diffs %0d done want 160 0 1",
                  got.size(), d, dc);
      end
   endtask

   task automatic test_hold();
      int da, dc, se, d, bad;
      bit va, ba;
      rand_regs();
      make_exp();
      do_start();
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         outReady = 1'b0;
         if (outValid !== 1'b1 || outData !== 8'h00) bad++;
         cyc();
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL hold_stalled: got %0d bad cycles want 0", bad);
      end
      collect(100, -1, 1'b0, -1, da, dc, se, va, ba);
      d = diff_cnt();
      n_tests++;
      if (d !== 0 || dc !== 1) begin
         n_fail++;
         $display("FAIL hold_frame: got %0d bytes %0d diffs %0d done want 160 0 1",
                  got.size(), d, dc);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      resetN   = 1'b0;
      start    = 1'b0;
      outReady = 1'b0;
      bus      = '0;
      test_reset();
      test_basic();
      cyc();
      test_backpressure();
      cyc();
      test_snapshot();
      cyc();
      test_ignore_start();
      cyc();
      test_abort();
      cyc();
      test_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_register_dumper.md
# debug_register_dumper

Streams a snapshot of the CPU register file out as a byte stream for board-level debug. On a `start` request it captures the flat 1024-bit `debug_registers` bus from the register file in one cycle. It then emits each register as an index byte followed by four data bytes over a valid/ready byte interface. That interface feeds the UART transmitter or a host FIFO.

## Interface
Parameters:
- `REG_COUNT`, 32: number of 32-bit registers in the snapshot; register 0 occupies bits [31:0].
- `REG_WIDTH`, 32: register width in bits; fixed at 4 bytes per register.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `resetN`  in  1  reset, synchronous and active-low.
- `start`  in  1  dump request; sampled only while `busy` is 0.
- `debug_registers`  in  REG_COUNT*REG_WIDTH  flat register image; register k is at bits [k*32 +: 32].
- `busy`  out  1  high from the cycle after an accepted `start` until the last byte handshakes.
- `outValid`  out  1  byte available on `outData`.
- `outReady`  in  1  consumer accepts the byte.
- `outData`  out  8  current byte.
- `done`  out  1  one-cycle pulse after the final byte handshakes.

## Operation
- Frame: for k = 0 to REG_COUNT-1, emit 5 bytes in order: k (8-bit index), then reg[k][31:24], [23:16], [15:8], [7:0]. Data bytes go MSB first.
- Frame length is REG_COUNT*5 bytes (160 by default). Register 0 is emitted even though it always reads 0.
- The snapshot register is loaded from `debug_registers` on the edge that accepts `start`. Changes to the bus during the dump are ignored.
- State machine:
  - IDLE: `start`=1 → load snapshot, clear regIndex and byteIndex, go to SEND.
  - SEND: `outValid`=1. On a handshake (`outValid && outReady`):
    - byteIndex 0→1→2→3→4, then wraps to 0 with regIndex+1.
    - A handshake at regIndex=REG_COUNT-1, byteIndex=4 → DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- Counter widths: regIndex is clog2(REG_COUNT) bits (5); byteIndex is 3 bits, range 0..4 only.
- Byte select: byteIndex 0 gives {3'b0, regIndex}. byteIndex b in 1..4 gives snapshot[regIndex*32 + (4-b)*8 +: 8].
- `start` while `busy`=1, or during DONE, is ignored. It is not queued.
- While `outValid`=1 and `outReady`=0, `outData` holds its value and `outValid` stays high. Valid never drops without a handshake.
- `outReady` is ignored while `outValid`=0.

## Timing
- Reset (`resetN`=0 at an edge): state IDLE. `busy`, `outValid` and `done` are 0. `outData`=0, counters are 0 and the snapshot is 0. Reset mid-dump aborts the frame with no `done`.
- `start` accepted at edge N: from cycle N+1, `busy`=1, `outValid`=1 and `outData`=0x00.
- With `outReady` held at 1, one byte transfers per cycle. The last handshake falls at edge N+160.
- In the cycle after the last handshake: `outValid`=0, `busy`=0, `done`=1. `start` is accepted one cycle later, in IDLE.
- All outputs are registered or decoded directly from state and registered counters. There is no combinational path from `outReady` or `start` to any output.

## Structure
- Shared package `debug_pkg` holds:
  - `BYTES_PER_REG`=5
  - `FRAME_BYTES`=REG_COUNT*BYTES_PER_REG
  - the state enum {IDLE, SEND, DONE}
- Sub-module `debug_byte_select`: purely combinational. Takes the snapshot, regIndex and byteIndex, and returns `outData`. It is kept separate so the VGA debug overlay can reuse it.

## Test plan
- Reset, then `start` with reg[1]=0x12345678 and `outReady`=1 → bytes 0x00,0,0,0,0 then 0x01,0x12,0x34,0x56,0x78. `done` is high in the cycle after the 160th byte.
- Back-pressure: toggle `outReady` randomly during reg[31]=0xDEADBEEF → `outData` stays stable while stalled. The tail reads 0x1F,0xDE,0xAD,0xBE,0xEF with no byte dropped or duplicated.
- Snapshot isolation: change reg[5] from 0xAAAA0000 to 0x5555FFFF two cycles after `start` → the frame still shows 0xAA,0xAA,0x00,0x00.
- `start` pulsed at byte 37 and again during the `done` cycle → both are ignored, and exactly one 160-byte frame is emitted.
- `resetN` low at byte 80 → the next cycle has `outValid`=0 and `busy`=0, and `done` never pulses. A new `start` restarts from byte 0x00.
- `outReady`=0 for 100 cycles after `start` → `outValid`=1 and `outData`=0x00 are held, with no counter advance.
